// File: rtl/microcode_sequencer.sv
// microcode_sequencer: fetches microwords from the EPROM, sequences the micro-PC
// and hands each microword to the datapath with a valid/stall handshake.
module microcode_sequencer #(
    parameter int          ACCESS_CYCLES = 1,
    parameter logic [7:0]  RESET_ADDR    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic        _cs,
    output logic        _oe,
    output logic [7:0]  addr,
    input  logic [63:0] data,
    input  logic        stall,
    input  logic [7:0]  cond,
    input  logic [7:0]  opcode,
    output logic [63:0] uword,
    output logic        uword_valid,
    output logic [7:0]  upc
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
    state_t      r_state, w_state_nxt;
    logic [7:0]  r_upc, r_ret, w_next, w_inc;
    logic [3:0]  r_cnt;
    logic [63:0] r_uword;
    logic        r_valid;
    logic [2:0]  w_op;
    logic        w_take, w_last, w_consume;
    always_comb begin
        w_op      = r_uword[55:53];
        w_inc     = r_upc + 8'd1;
        w_take    = cond[r_uword[52:50]] ^ r_uword[49];
        w_last    = r_cnt == 4'(ACCESS_CYCLES - 1);
        w_consume = (r_state == EXEC) && !stall;
        case (w_op)
            3'b001:  w_next = r_uword[63:56];
            3'b010:  w_next = w_take ? r_uword[63:56] : w_inc;
            3'b011:  w_next = opcode;
            3'b100:  w_next = r_uword[63:56];
            3'b101:  w_next = r_ret;
            3'b110:  w_next = r_upc;
            default: w_next = w_inc;
        endcase
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   w_state_nxt = w_last ? EXEC : FETCH;
            EXEC:    w_state_nxt = stall ? EXEC : (w_op == 3'b110 ? HALT : FETCH);
            default: w_state_nxt = HALT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_upc   <= RESET_ADDR;
            r_ret   <= 8'h00;
            r_cnt   <= 4'd0;
            r_uword <= 64'h0;
            r_valid <= 1'b0;
        end else begin
            if (r_state == FETCH) begin
                r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (w_last) begin
                    r_uword <= data;
                    r_valid <= 1'b1;
                end
            end
            if (w_consume) begin
                r_valid <= 1'b0;
                r_upc   <= w_next;
                if (w_op == 3'b100)
                    r_ret <= w_inc;
            end
        end
    end
    // The EPROM is only enabled while a fetch is in progress.
    assign _cs         = r_state != FETCH;
    assign _oe         = r_state != FETCH;
    assign addr        = r_upc;
    assign upc         = r_upc;
    assign uword       = r_uword;
    assign uword_valid = r_valid;
endmodule
